// File: rtl/caminho_extrator.sv
// caminho_extrator: walks the parent chain written by the pathfinder core,
// starting at destino and following parent links until fonte, streaming each
// node out over a valid/ready port (destino first, fonte last).
// Optional feature: define CAMINHO_LOOP_GUARD_EN to abort a run with an erro
// pulse once MAX_PASSOS non-final nodes have been transferred.
//
// Handshake: ext_no_out/ext_no_ultimo_out are offered while ext_no_valid_out is
// high and stay stable until the cycle ext_no_ready_in is also high; a node
// moves on every rising edge where valid and ready are both 1.
module caminho_extrator #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_PASSOS = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_iniciar_in,
  input  logic                  ext_alcancado_in,
  input  logic [ADDR_WIDTH-1:0] ext_addr_fonte_in,
  input  logic [ADDR_WIDTH-1:0] ext_addr_destino_in,
  output logic                  ext_pai_rd_out,
  output logic [ADDR_WIDTH-1:0] ext_pai_addr_out,
  input  logic [ADDR_WIDTH-1:0] ext_pai_data_in,
  output logic [ADDR_WIDTH-1:0] ext_no_out,
  output logic                  ext_no_valid_out,
  input  logic                  ext_no_ready_in,
  output logic                  ext_no_ultimo_out,
  output logic                  ext_ocupado_out,
  output logic                  ext_fim_out,
  output logic                  ext_erro_out,
  output logic [ADDR_WIDTH-1:0] ext_comprimento_out,
  output logic [1:0]            dbg_estado_out
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] EMITIR = 2'd1;
  localparam logic [1:0] LER    = 2'd2;
  localparam logic [1:0] ESPERA = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] COMP_MAX = '1;
`ifdef CAMINHO_LOOP_GUARD_EN
  localparam logic [ADDR_WIDTH-1:0] LIMITE = ADDR_WIDTH'(MAX_PASSOS);
`endif

  logic [1:0]            estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] node_q, node_d;
  logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
  logic [ADDR_WIDTH-1:0] comp_q, comp_d;
  logic                  fim_q, fim_d;
  logic                  erro_q, erro_d;
  logic                  ultimo;

  // Final node is recognised straight from the registered node, so it is
  // stable for as long as the node itself is held.
  assign ultimo = (estado_q == EMITIR) && (node_q == fonte_q);

  // Next-state logic: start handling, emission, and the two-cycle parent read.
  always_comb begin
    estado_d = estado_q;
    node_d   = node_q;
    fonte_d  = fonte_q;
    comp_d   = comp_q;
    fim_d    = 1'b0;
    erro_d   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (ext_iniciar_in) begin
          if (ext_alcancado_in) begin
            fonte_d  = ext_addr_fonte_in;
            node_d   = ext_addr_destino_in;
            comp_d   = '0;
            estado_d = EMITIR;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      EMITIR: begin
        if (ext_no_ready_in) begin
          if (comp_q != COMP_MAX) begin
            comp_d = comp_q + 1'b1;
          end
          if (ultimo) begin
            fim_d    = 1'b1;
            estado_d = OCIOSO;
          end else begin
`ifdef CAMINHO_LOOP_GUARD_EN
            if (comp_d == LIMITE) begin
              erro_d   = 1'b1;
              estado_d = OCIOSO;
            end else begin
              estado_d = LER;
            end
`else
            estado_d = LER;
`endif
          end
        end
      end
      LER: begin
        estado_d = ESPERA;
      end
      ESPERA: begin
        node_d   = ext_pai_data_in;
        estado_d = EMITIR;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State registers; reset drops any run in progress without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      node_q   <= '0;
      fonte_q  <= '0;
      comp_q   <= '0;
      fim_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      node_q   <= node_d;
      fonte_q  <= fonte_d;
      comp_q   <= comp_d;
      fim_q    <= fim_d;
      erro_q   <= erro_d;
    end
  end

  assign ext_pai_rd_out      = (estado_q == LER);
  assign ext_pai_addr_out    = node_q;
  assign ext_no_out          = node_q;
  assign ext_no_valid_out    = (estado_q == EMITIR);
  assign ext_no_ultimo_out   = ultimo;
  assign ext_ocupado_out     = (estado_q != OCIOSO);
  assign ext_fim_out         = fim_q;
  assign ext_erro_out        = erro_q;
  assign ext_comprimento_out = comp_q;
  assign dbg_estado_out      = estado_q;

endmodule

// File: doc/caminho_extrator.md
CAMINHO_EXTRATOR -- requirements
Module: caminho_extrator

Interface
REQ-001 Parameter ADDR_WIDTH, 10, node address width; matches pathfinder core.
REQ-002 Parameter MAX_PASSOS, 1023, loop-guard node limit (see Configuration).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ext_iniciar_in  input  1  one-cycle start pulse; core search finished.
REQ-006 ext_alcancado_in  input  1  core reached destino; sampled with start.
REQ-007 ext_addr_fonte_in  input  ADDR_WIDTH  source node; sampled with start.
REQ-008 ext_addr_destino_in  input  ADDR_WIDTH  destination node; sampled with start.
REQ-009 ext_pai_rd_out  output  1  parent-memory read strobe.
REQ-010 ext_pai_addr_out  output  ADDR_WIDTH  parent-memory read address.
REQ-011 ext_pai_data_in  input  ADDR_WIDTH  parent of addressed node; valid exactly 1 cycle after strobe.
REQ-012 ext_no_out  output  ADDR_WIDTH  path node, destino first, fonte last.
REQ-013 ext_no_valid_out  output  1  ext_no_out valid.
REQ-014 ext_no_ready_in  input  1  consumer accepts; transfer = valid AND ready.
REQ-015 ext_no_ultimo_out  output  1  current node is fonte (final node).
REQ-016 ext_ocupado_out  output  1  extraction in progress.
REQ-017 ext_fim_out  output  1  one-cycle pulse: path fully emitted.
REQ-018 ext_erro_out  output  1  one-cycle pulse: no path or loop abort.
REQ-019 ext_comprimento_out  output  ADDR_WIDTH  nodes transferred in current/last run; saturates at all-ones.

Function
REQ-020 FSM states SHALL be OCIOSO, EMITIR, LER, ESPERA.
REQ-021 OCIOSO + start + alcancado=1 SHALL latch fonte/destino, clear comprimento, load node=destino, go EMITIR next cycle.
REQ-022 OCIOSO + start + alcancado=0 SHALL pulse ext_erro_out next cycle, emit nothing, stay OCIOSO.
REQ-023 ext_iniciar_in outside OCIOSO SHALL be ignored.
REQ-024 EMITIR SHALL assert valid; ext_no_ultimo_out = (node == latched fonte), combinational from registered node.
REQ-025 While valid and not ready, ext_no_out and ext_no_ultimo_out SHALL hold stable.
REQ-026 On transfer, comprimento SHALL increment; if ultimo, pulse ext_fim_out next cycle and go OCIOSO; else go LER.
REQ-027 LER SHALL assert ext_pai_rd_out for one cycle with ext_pai_addr_out = node, then go ESPERA.
REQ-028 ESPERA SHALL capture ext_pai_data_in into node and go EMITIR; accept-to-next-valid latency = 3 cycles.
REQ-029 fonte == destino SHALL emit one node with ultimo=1 and no memory read.
REQ-030 ext_ocupado_out SHALL be 1 in EMITIR, LER, ESPERA; 0 in OCIOSO.
REQ-031 ext_pai_rd_out SHALL be 0 outside LER; ext_pai_addr_out may be any value when strobe low.

Reset
REQ-032 rst_n low SHALL asynchronously force OCIOSO; valid, ultimo, rd, ocupado, fim, erro = 0; node, addr, comprimento = 0.
REQ-033 Reset mid-run SHALL abandon the run silently: no fim or erro pulse after release.
REQ-034 First start is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-035 Macro CAMINHO_LOOP_GUARD_EN defined: a transfer that makes comprimento == MAX_PASSOS with ultimo=0 SHALL pulse ext_erro_out next cycle and go OCIOSO instead of LER.
REQ-036 Macro undefined: no guard; extraction runs until fonte is emitted, possibly forever on a corrupt parent chain.

Verification
REQ-037 pai[12]=7, pai[7]=3, pai[3]=2; start fonte=2 destino=12, ready=1 -> nodes 12,7,3,2, ultimo only on 2, fim pulse, comprimento=4, 3 reads at addresses 12,7,3.
REQ-038 Same path, ready toggled 1-of-3 cycles -> identical sequence; outputs stable while stalled; no node lost or repeated.
REQ-039 fonte=destino=5 -> single node 5 with ultimo=1, no rd strobe, fim pulse, comprimento=1.
REQ-040 Start with alcancado=0 -> erro pulse one cycle later, valid never asserted, ocupado stays 0.
REQ-041 With CAMINHO_LOOP_GUARD_EN, MAX_PASSOS=16, pai[9]=8, pai[8]=9, fonte=2 destino=9 -> 16 nodes alternating 9,8, then erro pulse, no fim.
REQ-042 rst_n low during ESPERA of the REQ-037 run -> all outputs 0 immediately; a new run after release emits the correct full sequence.
